// File: rtl/pipo_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin PIPO arbiter:
// the holding-register state, source-index sizing and a wrapping index rotate.
package pipo_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  // Smallest w with 2**w >= n, never below 1 so a 2-requester arbiter still has an index bit.
  function automatic int unsigned src_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned k = 1; k < 32; k++) begin
      if ((32'd1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

  // (base + off) wrapped into 0..n-1.
  function automatic int unsigned rot_idx(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/pipo_rr_arbiter_if.sv
// Requester and consumer handshake bundle of the arbiter.
// The arbiter sits on the slave modport; the environment drives the master side.
interface pipo_rr_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SRC_W = 2
);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [SRC_W-1:0]       out_src;
  logic                   out_ready;

  modport master (
    output req_valid,
    output req_data,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_src
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_data,
    output out_src
  );

endinterface

// File: rtl/pipo_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req_valid bit at or after rr_ptr,
// scanning upward and wrapping past N_REQ-1.
module rr_pick
  import pipo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned SRC_W = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [SRC_W-1:0] rr_ptr,
  output logic [SRC_W-1:0] winner,
  output logic             any_valid
);

  logic             found;
  logic [SRC_W-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = SRC_W'(rot_idx(32'(rr_ptr), k, N_REQ));
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign any_valid = |req_valid;

endmodule

// File: rtl/pipo_rr_arbiter.sv
// Round-robin arbiter feeding one shared WIDTH-bit holding register; the captured
// word is presented with its source index until the consumer takes it.
module pipo_rr_arbiter
  import pipo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SRC_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  pipo_rr_arbiter_if.slave bus
);

  if (SRC_W != src_width(N_REQ)) begin : g_bad_src_w
    $error("pipo_rr_arbiter: SRC_W must equal clog2(N_REQ)");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("pipo_rr_arbiter: N_REQ must be in 2..8");
  end

  arb_state_e       state_q, state_d;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] winner;
  logic             any_valid;
  logic             can_load;
  logic             grant;
  logic             valid_o;
  logic [N_REQ-1:0] ready_o;
  logic [WIDTH-1:0] data_q;
  logic [SRC_W-1:0] src_q;

  rr_pick #(
    .N_REQ (N_REQ),
    .SRC_W (SRC_W)
  ) u_pick (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  // rst gates the grant so no requester sees ready while reset is held.
  always_comb begin
    state_d  = state_q;
    valid_o  = 1'b0;
    ready_o  = '0;
    can_load = (state_q == EMPTY) || bus.out_ready;
    grant    = rst && can_load && any_valid;

    case (state_q)
      EMPTY: valid_o = 1'b0;
      FULL:  valid_o = 1'b1;
      default: valid_o = 1'b0;
    endcase

    if (grant) begin
      state_d         = FULL;
      ready_o[winner] = 1'b1;
    end else if (state_q == FULL && bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      src_q  <= '0;
      rr_ptr <= '0;
    end else if (grant) begin
      data_q <= bus.req_data[winner*WIDTH +: WIDTH];
      src_q  <= winner;
      rr_ptr <= SRC_W'(rot_idx(32'(winner), 1, N_REQ));
    end
  end

  assign bus.req_ready = ready_o;
  assign bus.out_valid = valid_o;
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

endmodule

// File: doc/pipo_rr_arbiter.md
Name: pipo_rr_arbiter

Overview:
- Shares one WIDTH-bit parallel-in/parallel-out holding register among N_REQ requesters.
- Each requester offers a parallel word using a valid/ready handshake. A round-robin pointer picks one winner per cycle, and the winner's word is captured into the register.
- The word is presented downstream with its source index until the consumer accepts it.
- Sits between the per-lane data producers and the single shared downstream register consumer in the shift-register datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 4, data width of each parallel word.
- SRC_W, 2, width of the source index; must equal clog2(N_REQ), checked at elaboration.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  N_REQ  bit i set = requester i offers a word.
- req_data  in  N_REQ*WIDTH  word of requester i at bits [i*WIDTH +: WIDTH].
- req_ready  out  N_REQ  one-hot grant; requester i's word is taken in a cycle where req_valid[i] and req_ready[i] are both 1.
- out_valid  out  1  holding register contains an unconsumed word.
- out_data  out  WIDTH  captured word.
- out_src  out  SRC_W  index of the requester that supplied out_data.
- out_ready  in  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, out_src=0, rr_ptr=0, state=EMPTY.
  - req_ready is forced to 0 while rst=0.
- Two-state FSM:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_load = (state==EMPTY) | out_ready. A load in the same cycle as a drain is allowed, giving one word per cycle of throughput.
- Winner selection (combinational):
  - Scan req_valid starting at index rr_ptr, ascending, wrapping from N_REQ-1 to 0.
  - The first set bit wins.
  - req_ready = onehot(winner) when can_load and at least one req_valid is set, otherwise 0.
  - req_ready never depends on any requester other than the winner, and never has more than one bit set.
- Grant cycle (any req_valid set and can_load), at the next rising edge:
  - out_data <= winner's word.
  - out_src <= winner.
  - state <= FULL.
  - rr_ptr <= (winner+1) mod N_REQ.
- Drain without a grant (FULL, out_ready=1, no req_valid): state <= EMPTY, out_valid falls next cycle.
  - out_data and out_src keep their last value; they are don't-care when out_valid=0.
- FULL, out_ready=0: out_data, out_src and rr_ptr hold; req_ready=0. A requester keeps req_valid and req_data stable until granted.
- Latency: req_valid to out_valid is 1 cycle when the register is empty or draining.
- Fairness: a continuously asserted requester waits at most N_REQ-1 grants.
- rr_ptr changes only on a grant. Idle cycles do not move it.
- out_ready in EMPTY is ignored.
- Reset mid-transfer: the pending word is discarded and no grant is reported. After release, the first grant scans from index 0.

Decomposition:
- Shared package pipo_arb_pkg holds:
  - the state enum (EMPTY, FULL);
  - a function computing SRC_W from N_REQ;
  - a rotate-index helper.
- One sub-module, rr_pick: purely combinational. Inputs are req_valid and rr_ptr; outputs are winner index and any_valid.
- The top level holds the FSM, rr_ptr and the holding register.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all req_valid=1 → req_ready=0000, out_valid=0, out_data=0, out_src=0.
- Single requester: req_valid=0100, data[2]=4'hA, out_ready=1 → req_ready=0100 in that cycle; next cycle out_valid=1, out_data=A, out_src=2, rr_ptr=3.
- Round robin: req_valid=1111 held with out_ready=1, data i = i+5 → out_src sequence 0,1,2,3,0, out_data 5,6,7,8,5, one word per cycle.
- Backpressure: FULL holding 4'h3 with out_ready=0 for 4 cycles while req_valid=0010 → req_ready=0000, out_data stays 3, rr_ptr unchanged; when out_ready=1, grant to 1 in that same cycle.
- Wrap and skip: rr_ptr=3, req_valid=0011 → winner 0 then 1; rr_ptr ends at 2.
- Reset mid-operation: FULL with out_data=4'hC, pull rst low for 1 cycle → out_valid=0 asynchronously; after release, req_valid=1000 → out_src=3 one cycle later.
